// File: rtl/pwm_decoder.sv
// Three-channel PWM duty decoder: measures high clocks per fixed 256-clock window.
// Define PWM_DEC_STABLE_EN to publish results only when two consecutive windows agree.
module pwm_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       R_in,
  input  logic       G_in,
  input  logic       B_in,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       valid,
  output logic       locked
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, RUN} state_t;

  state_t            state, state_nx;
  logic [7:0]        win_cnt;
  logic [2:0]        sync1, sync2;     // bit 2 = red, 1 = green, 0 = blue
  logic [2:0][8:0]   acc;
  logic [2:0][8:0]   sum;
  logic [2:0][7:0]   res;
  logic              win_end;
  logic              clr;
  logic              acq_done;
  logic              update;

  assign win_end = (win_cnt == 8'hFF);
  assign clr     = !en || (state == IDLE);
  assign locked  = (state == RUN);

  // Window result includes the sample taken on the last window clock.
  // NOTE: every signal driven in always_comb is assigned first, so no path leaves it unassigned (no latch).
  always_comb begin
    sum = '0;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      sum[i] = acc[i] + {8'd0, sync2[i]};
      res[i] = sum[i][8] ? 8'hFF : sum[i][7:0];
    end
  end

`ifdef PWM_DEC_STABLE_EN
  logic [2:0][7:0] prev;
  logic            acq_seen;

  // One discarded window, then one reference window before RUN.
  assign acq_done = acq_seen;
  assign update   = (res == prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      acq_seen <= 1'b0;
    end else if (clr) begin
      acq_seen <= 1'b0;
    end else if (win_end) begin
      prev <= res;
      if (state == ACQUIRE) acq_seen <= 1'b1;
    end
  end
`else
  assign acq_done = 1'b1;
  assign update   = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = ACQUIRE;
        ACQUIRE: if (win_end && acq_done) state_nx = RUN;
        RUN:     state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // R/G/B are deliberately left untouched by clr so they hold across a disable.
  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      sync1   <= '0;
      sync2   <= '0;
      acc     <= '0;
      R       <= '0;
      G       <= '0;
      B       <= '0;
      valid   <= 1'b0;
    end else if (clr) begin
      win_cnt <= '0;
      sync1   <= '0;
      sync2   <= '0;
      acc     <= '0;
      valid   <= 1'b0;
    end else begin
      sync1   <= {R_in, G_in, B_in};
      sync2   <= sync1;
      win_cnt <= win_cnt + 8'd1;
      valid   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc[i] <= win_end ? 9'd0 : sum[i];
      end
      if (win_end && (state == RUN) && update) begin
        {R, G, B} <= res;
        valid     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 The block SHALL have no parameters; the PWM period SHALL be fixed at 256 clocks.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  decode enable; low SHALL hold the block idle.
REQ-005 R_in  input  1  red PWM stream, asynchronous to clk.
REQ-006 G_in  input  1  green PWM stream, asynchronous to clk.
REQ-007 B_in  input  1  blue PWM stream, asynchronous to clk.
REQ-008 R  output  8  decoded red duty, in high clocks per 256.
REQ-009 G  output  8  decoded green duty.
REQ-010 B  output  8  decoded blue duty.
REQ-011 valid  output  1  one-cycle strobe when R/G/B are updated.
REQ-012 locked  output  1  high while in RUN state.

Function
REQ-013 Each *_in SHALL pass through a 2-flop synchronizer; decoding SHALL use only synchronized samples (2-cycle input latency).
REQ-014 A free-running 8-bit window counter win_cnt SHALL count 0..255 and wrap to 0; it SHALL advance only when en=1.
REQ-015 Per channel, a 9-bit accumulator SHALL add 1 for each cycle with a high synchronized sample inside the window.
REQ-016 On the cycle where win_cnt=255, window result SHALL be acc + current sample, saturated to 255; acc SHALL be cleared for the next window.
REQ-017 Because the source period is 256, the result SHALL equal the source duty regardless of phase between source and window.
REQ-018 States: IDLE, ACQUIRE, RUN.
REQ-019 IDLE: win_cnt, acc and synchronizers cleared; en=1 SHALL move to ACQUIRE on the next edge.
REQ-020 ACQUIRE: the first complete window result SHALL be discarded (no output update, valid=0); at its end the state SHALL become RUN.
REQ-021 RUN: at each window end the block SHALL register results into R/G/B and pulse valid on the following cycle, so valid and new values appear together.
REQ-022 en=0 in any state SHALL return the block to IDLE on the next edge, abandon the partial window, force valid=0 and locked=0, and hold R/G/B at their last values.
REQ-023 A constant-high input SHALL decode as 255; a constant-low input SHALL decode as 0.
REQ-024 locked SHALL be 1 exactly while in RUN.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, win_cnt=0, all acc=0, synchronizers=0, R=G=B=0, valid=0, locked=0, including mid-window.
REQ-026 After rst deasserts, decoding SHALL restart from IDLE; no partial-window result SHALL ever be output.

Configuration
REQ-027 Macro PWM_DEC_STABLE_EN SHALL select output stability filtering.
REQ-028 With PWM_DEC_STABLE_EN defined: the block SHALL keep the previous window's three results; in RUN, R/G/B SHALL update and valid SHALL pulse only when all three current results equal the previous ones; otherwise outputs SHALL hold and valid SHALL stay 0.
REQ-029 With PWM_DEC_STABLE_EN defined: ACQUIRE SHALL span one discarded window plus one reference window, so the first update occurs at the end of the third window.
REQ-030 Without PWM_DEC_STABLE_EN: every RUN window SHALL update outputs and pulse valid, and no history registers SHALL be built.

Verification
REQ-031 Reset, en=1, and source driving R=0x40, G=0x80, B=0xFF at arbitrary phase SHALL give first valid with R=0x40, G=0x80, B=0xFF after window 2 (window 3 with macro); valid SHALL then pulse once every 256 cycles.
REQ-032 R_in held 0 and G_in held 1 SHALL decode as R=0x00 and G=0xFF; a 257-cycle high glitch SHALL saturate to 0xFF, never wrap to 0.
REQ-033 A source step from R=0x10 to R=0x20: without the macro, a mixed-window value may appear once, then 0x20; with the macro, no value other than 0x10 or 0x20 SHALL ever be output.
REQ-034 en dropped at win_cnt=100 SHALL give locked=0 next cycle, outputs held, and no valid; on re-enable, the ACQUIRE sequence SHALL repeat.
REQ-035 rst pulsed mid-window with R=0x55 SHALL immediately zero all outputs; after release, the first valid SHALL show 0x55.
